// File: rtl/uart_axis_deframer.sv
// UART byte stream to AXI-Stream word deframer: sync hunt, little-endian payload assembly,
// inter-byte timeout and overflow flagging. Optional XOR checksum byte under `DEFRAMER_CSUM_EN.
module uart_axis_deframer #(
    parameter int                       BITS_PER_WORD = 8,
    parameter int                       W_OUT         = 224,
    parameter logic [BITS_PER_WORD-1:0] SYNC_BYTE     = 8'hA5,
    parameter int                       TIMEOUT_CLKS  = 200_000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    input  logic [BITS_PER_WORD-1:0] s_data,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [W_OUT-1:0]         m_axis_tdata,
    output logic                     err_timeout,
    output logic                     err_overflow,
    output logic                     err_csum
);

    localparam int N_BYTES = (W_OUT + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int W_CNT   = $clog2(N_BYTES + 1);
    localparam int W_TMR   = $clog2(TIMEOUT_CLKS + 1);

`ifdef DEFRAMER_CSUM_EN
    typedef enum logic [1:0] {HUNT, PAYLOAD, CSUM} state_e;
`else
    typedef enum logic [0:0] {HUNT, PAYLOAD} state_e;
`endif

    state_e               state_q, state_d;
    logic [W_CNT-1:0]     cnt_q, cnt_d;
    logic [W_TMR-1:0]     timer_q, timer_d;
    logic [W_OUT-1:0]     asm_q, asm_d;
    logic                 tvalid_q, tvalid_d;
    logic [W_OUT-1:0]     tdata_q, tdata_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_overflow_q, err_overflow_d;
    logic                 commit;
`ifdef DEFRAMER_CSUM_EN
    logic [BITS_PER_WORD-1:0] csum_q, csum_d;
    logic                     err_csum_q, err_csum_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        asm_d          = asm_q;
        tvalid_d       = tvalid_q & ~m_axis_tready;
        tdata_d        = tdata_q;
        err_timeout_d  = 1'b0;
        err_overflow_d = 1'b0;
        commit         = 1'b0;
`ifdef DEFRAMER_CSUM_EN
        csum_d         = csum_q;
        err_csum_d     = 1'b0;
`endif
        case (state_q)
            HUNT: begin
                timer_d = '0;
                cnt_d   = '0;
                if (s_valid && s_data == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    asm_d   = '0;
`ifdef DEFRAMER_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            PAYLOAD: begin
                if (s_valid) begin
                    timer_d = '0;
                    // Bits of the last byte that fall beyond W_OUT are simply not stored.
                    for (int k = 0; k < N_BYTES; k++) begin
                        for (int i = 0; i < BITS_PER_WORD; i++) begin
                            if (k * BITS_PER_WORD + i < W_OUT && cnt_q == W_CNT'(k))
                                asm_d[k * BITS_PER_WORD + i] = s_data[i];
                        end
                    end
`ifdef DEFRAMER_CSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    if (cnt_q == W_CNT'(N_BYTES - 1)) begin
                        cnt_d = '0;
`ifdef DEFRAMER_CSUM_EN
                        state_d = CSUM;
`else
                        state_d = HUNT;
                        commit  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef DEFRAMER_CSUM_EN
            CSUM: begin
                if (s_valid) begin
                    timer_d = '0;
                    state_d = HUNT;
                    if (s_data == csum_q) commit = 1'b1;
                    else                  err_csum_d = 1'b1;
                end
            end
`endif
            default: state_d = HUNT;
        endcase

        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (state_q != HUNT && !s_valid) begin
            if (timer_q == W_TMR'(TIMEOUT_CLKS - 1)) begin
                state_d       = HUNT;
                cnt_d         = '0;
                timer_d       = '0;
                err_timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (commit) begin
            if (!tvalid_q || m_axis_tready) begin
                tvalid_d = 1'b1;
                tdata_d  = asm_d;
            end else begin
                err_overflow_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state math lives above.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= HUNT;
            cnt_q          <= '0;
            timer_q        <= '0;
            asm_q          <= '0;
            tvalid_q       <= 1'b0;
            tdata_q        <= '0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
`ifdef DEFRAMER_CSUM_EN
            csum_q         <= '0;
            err_csum_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            asm_q          <= asm_d;
            tvalid_q       <= tvalid_d;
            tdata_q        <= tdata_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
`ifdef DEFRAMER_CSUM_EN
            csum_q         <= csum_d;
            err_csum_q     <= err_csum_d;
`endif
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign err_timeout   = err_timeout_q;
    assign err_overflow  = err_overflow_q;
`ifdef DEFRAMER_CSUM_EN
    assign err_csum      = err_csum_q;
`else
    assign err_csum      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_axis_deframer.sv
// Self-checking bench for uart_axis_deframer: table-driven frames with a word scoreboard,
// plus hand sequences for overflow, timeout, reset, checksum and W_OUT=20 truncation.
module tb_uart_axis_deframer;

    localparam int W  = 224;
    localparam int NB = 28;
    localparam int T  = 40;

    logic           clk;
    logic           rstn;
    logic           s_valid;
    logic [7:0]     s_data;
    logic           tready;
    logic           tvalid;
    logic [W-1:0]   tdata;
    logic           err_to, err_ov, err_cs;

    logic           s_valid2;
    logic [7:0]     s_data2;
    logic           tready2;
    logic           tvalid2;
    logic [19:0]    tdata2;
    logic           err_to2, err_ov2, err_cs2;

    uart_axis_deframer #(
        .BITS_PER_WORD(8), .W_OUT(W), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)
    ) u_dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
        .err_timeout(err_to), .err_overflow(err_ov), .err_csum(err_cs)
    );

    uart_axis_deframer #(
        .BITS_PER_WORD(8), .W_OUT(20), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)
    ) u_small (
        .clk(clk), .rstn(rstn), .s_valid(s_valid2), .s_data(s_data2),
        .m_axis_tready(tready2), .m_axis_tvalid(tvalid2), .m_axis_tdata(tdata2),
        .err_timeout(err_to2), .err_overflow(err_ov2), .err_csum(err_cs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_word(input logic [7:0] base, input logic [7:0] step);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < NB; k++) w[8*k +: 8] = base + 8'(int'(step) * k);
        return w;
    endfunction

    // Scoreboard and error-pulse monitor
    logic [W-1:0] sb_q[$];
    logic [W-1:0] last_word;
    int  n_to = 0, n_ov = 0, n_cs = 0;
    logic p_to, p_ov, p_cs;

    always @(negedge clk) begin
        if (!rstn) begin
            p_to = 1'b0; p_ov = 1'b0; p_cs = 1'b0;
        end else begin
            if (tvalid && tready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word act=%h req=none", tdata);
                end else begin
                    check("sb_word", tdata, sb_q.pop_front());
                    last_word = tdata;
                end
            end
            if (err_to) begin check("err_timeout_width", W'(p_to), '0); if (!p_to) n_to++; end
            if (err_ov) begin check("err_overflow_width", W'(p_ov), '0); if (!p_ov) n_ov++; end
            if (err_cs) begin check("err_csum_width", W'(p_cs), '0); if (!p_cs) n_cs++; end
            p_to = err_to; p_ov = err_ov; p_cs = err_cs;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 s_valid = 1'b1; s_data = b;
        @(posedge clk); #1 s_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        @(posedge clk); #1 s_valid2 = 1'b1; s_data2 = b;
        @(posedge clk); #1 s_valid2 = 1'b0;
    endtask

    // Full frame; optional idle stretch of gap_n extra cycles before payload byte gap_at.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] step,
                              input int gap_at, input int gap_n, input bit push);
        logic [7:0] b, x;
        x = '0;
        send_byte(8'hA5);
        for (int k = 0; k < NB; k++) begin
            b = base + 8'(int'(step) * k);
            if (k == gap_at) repeat (gap_n) @(posedge clk);
            send_byte(b);
            x ^= b;
        end
`ifdef DEFRAMER_CSUM_EN
        send_byte(x);
`endif
        if (push) sb_q.push_back(model_word(base, step));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !tvalid) return;
        end
        check("drain_bound", W'(sb_q.size()), '0);
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        bit         garbage;
        int         hold;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h01, 8'h01, 1'b0, 0, 8'h01, 8'h1C};
        vecs[1] = '{8'h01, 8'h01, 1'b1, 0, 8'h01, 8'h1C};
        vecs[2] = '{8'h00, 8'h11, 1'b0, 5, 8'h00, 8'hCB};
        vecs[3] = '{8'hA5, 8'h00, 1'b0, 3, 8'hA5, 8'hA5};
        vecs[4] = '{8'hF0, 8'hFF, 1'b1, 0, 8'hF0, 8'hD5};

        rstn = 1'b1; s_valid = 1'b0; s_data = '0; tready = 1'b1;
        s_valid2 = 1'b0; s_data2 = '0; tready2 = 1'b1; last_word = '0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", W'(tvalid), '0);
        check("rst_tdata", tdata, '0);
        check("rst_errs", W'({err_to, err_ov, err_cs}), '0);
        @(negedge clk) rstn = 1'b1;

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].garbage) begin
                send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
            end
            if (vecs[v].hold > 0) tready = 1'b0;
            send_frame(vecs[v].base, vecs[v].step, -1, 0, 1'b1);
            if (vecs[v].hold == 0) begin
                @(negedge clk); check("latency_tvalid_hi", W'(tvalid), W'(1));
                @(negedge clk); check("single_cycle_tvalid", W'(tvalid), '0);
            end else begin
                repeat (vecs[v].hold) @(negedge clk);
                check("hold_tvalid", W'(tvalid), W'(1));
                check("hold_tdata_stable", tdata, model_word(vecs[v].base, vecs[v].step));
                tready = 1'b1;
            end
            wait_idle();
            check("word_lo", W'(last_word[7:0]), W'(vecs[v].exp_lo));
            check("word_hi", W'(last_word[223:216]), W'(vecs[v].exp_hi));
        end
        check("no_err_after_table", W'({n_to[7:0], n_ov[7:0], n_cs[7:0]}), '0);

        // Overflow: second frame dropped while first word is held
        tready = 1'b0;
        send_frame(8'h11, 8'h01, -1, 0, 1'b1);
        send_frame(8'h22, 8'h01, -1, 0, 1'b0);
        @(negedge clk);
        check("overflow_pulse", W'(err_ov), W'(1));
        check("overflow_keeps_first", tdata, model_word(8'h11, 8'h01));
        @(negedge clk);
        check("overflow_pulse_end", W'(err_ov), '0);
        check("overflow_count", W'(n_ov), W'(1));
        tready = 1'b1;
        wait_idle();
        check("overflow_drained", W'(tvalid), '0);

        // Timeout on a partial frame, then a clean frame
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i));
        repeat (T + 10) @(posedge clk);
        check("timeout_count", W'(n_to), W'(1));
        send_frame(8'h40, 8'h03, -1, 0, 1'b1);
        wait_idle();
        // Gap of exactly TIMEOUT_CLKS edges: byte coincides with expiry and wins
        send_frame(8'h30, 8'h02, 5, T - 2, 1'b1);
        wait_idle();
        check("timeout_boundary_ok", W'(n_to), W'(1));
        // One cycle longer: frame aborted
        send_frame(8'h00, 8'h00, 5, T - 1, 1'b0);
        repeat (T + 5) @(posedge clk);
        check("timeout_boundary_abort", W'(n_to), W'(2));
        check("timeout_no_word", W'(tvalid), '0);

`ifdef DEFRAMER_CSUM_EN
        // Checksum: 28 x 01 XORs to 00
        send_byte(8'hA5);
        for (int k = 0; k < NB; k++) send_byte(8'h01);
        send_byte(8'h00);
        sb_q.push_back(model_word(8'h01, 8'h00));
        wait_idle();
        check("csum_good_word", last_word, model_word(8'h01, 8'h00));
        send_byte(8'hA5);
        for (int k = 0; k < NB; k++) send_byte(8'h01);
        send_byte(8'h01);
        repeat (5) @(negedge clk);
        check("csum_bad_count", W'(n_cs), W'(1));
        check("csum_bad_no_word", W'(tvalid), '0);
`endif

        // Reset mid-payload
        send_byte(8'hA5);
        for (int i = 0; i < 14; i++) send_byte(8'h60 + 8'(i));
        @(negedge clk) rstn = 1'b0;
        #1 check("rst_mid_outputs", W'({tvalid, err_to, err_ov, err_cs}), '0);
        @(negedge clk) rstn = 1'b1;
        // Reset with a pending word
        tready = 1'b0;
        send_frame(8'h77, 8'h05, -1, 0, 1'b0);
        @(negedge clk);
        check("pending_tdata", tdata, model_word(8'h77, 8'h05));
        rstn = 1'b0;
        #1;
        check("rst_pending_tvalid", W'(tvalid), '0);
        check("rst_pending_tdata", tdata, '0);
        @(negedge clk) rstn = 1'b1;
        tready = 1'b1;
        send_frame(8'h09, 8'h07, -1, 0, 1'b1);
        wait_idle();
        check("post_reset_word", last_word, model_word(8'h09, 8'h07));

        // W_OUT=20: 12 34 56 -> 0x63412, top nibble of last byte dropped
        send_byte2(8'hA5); send_byte2(8'h12); send_byte2(8'h34); send_byte2(8'h56);
`ifdef DEFRAMER_CSUM_EN
        send_byte2(8'h70);
`endif
        @(negedge clk);
        check("small_tvalid", W'(tvalid2), W'(1));
        check("small_tdata", W'(tdata2), W'(20'h63412));
        @(negedge clk);
        check("small_tvalid_drop", W'(tvalid2), '0);
        check("small_errs", W'({err_to2, err_ov2, err_cs2}), '0);

`ifdef DEFRAMER_CSUM_EN
        check("final_csum_count", W'(n_cs), W'(1));
`else
        check("final_csum_count", W'(n_cs), '0);
`endif
        check("final_overflow_count", W'(n_ov), W'(1));
        check("final_sb_empty", W'(sb_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

endmodule
